// File: rtl/motion_executor_if.sv
// motion_executor_if: command/speed bus from the motion-decision layer plus wheel drive and spin status back
interface motion_executor_if;
    logic       enable;
    logic [9:0] motion_command;
    logic [2:0] speed;
    logic       left_dir;
    logic       right_dir;
    logic       left_pwm;
    logic       right_pwm;
    logic       done_spin;
    logic       busy;

    modport master (
        output enable, motion_command, speed,
        input  left_dir, right_dir, left_pwm, right_pwm, done_spin, busy
    );

    modport slave (
        input  enable, motion_command, speed,
        output left_dir, right_dir, left_pwm, right_pwm, done_spin, busy
    );
endinterface

// File: rtl/motion_executor.sv
// motion_executor: turns motion commands into wheel dir/PWM, times spins and holds done_spin; MOTION_BRAKE_EN adds a brake interval before spins entered from DRIVE
module motion_executor #(
    parameter int TICKS_PER_DEG = 4,
    parameter int PWM_DIV       = 1,
    parameter int BRAKE_CYCLES  = 16
) (
    input logic               clk,
    input logic               rst,
    motion_executor_if.slave  bus
);
`ifdef MOTION_BRAKE_EN
    typedef enum logic [2:0] {IDLE = 3'd0, DRIVE = 3'd1, SPIN = 3'd2, DONE = 3'd3, BRAKE = 3'd4} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, DRIVE = 3'd1, SPIN = 3'd2, DONE = 3'd3} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [9:0]  lcmd_q, lcmd_d;
    logic        dir_q, dir_d;
    logic [8:0]  mag_q, mag_d;
    logic [1:0]  slot_q, slot_d;
    logic [31:0] pre_q, pre_d;
`ifdef MOTION_BRAKE_EN
    logic [31:0] brk_q, brk_d;
`endif
    logic        left_dir_q, left_dir_d;
    logic        right_dir_q, right_dir_d;
    logic        left_pwm_q, left_pwm_d;
    logic        right_pwm_q, right_pwm_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic        cmd_nz;
    logic [8:0]  mag_in;
    logic        latch;
    logic        drive_n, spin_n;
    logic [1:0]  duty;

    assign cmd_nz = |bus.motion_command;
    assign mag_in = bus.motion_command[8:0] > 9'd360 ? 9'd360 : bus.motion_command[8:0];

    // Next state, spin counter and latched command; disable overrides everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lcmd_d  = lcmd_q;
        dir_d   = dir_q;
        mag_d   = mag_q;
        latch   = 1'b0;
`ifdef MOTION_BRAKE_EN
        brk_d   = brk_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = cmd_nz ? SPIN : DRIVE;
                latch   = cmd_nz;
            end
            DRIVE: begin
                if (cmd_nz) begin
`ifdef MOTION_BRAKE_EN
                    state_d = BRAKE;
                    brk_d   = '0;
`else
                    state_d = SPIN;
`endif
                    latch   = 1'b1;
                end
            end
`ifdef MOTION_BRAKE_EN
            BRAKE: begin
                if (brk_q == 32'(BRAKE_CYCLES - 1)) state_d = SPIN;
                else brk_d = brk_q + 32'd1;
            end
`endif
            SPIN: begin
                if (cnt_q == '0) state_d = DONE;
                else cnt_d = cnt_q - 32'd1;
            end
            DONE: begin
                if (!cmd_nz) state_d = DRIVE;
                else if (bus.motion_command != lcmd_q) begin
                    state_d = SPIN;
                    latch   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (latch && bus.enable) begin
            lcmd_d = bus.motion_command;
            dir_d  = bus.motion_command[9];
            mag_d  = mag_in;
            cnt_d  = 32'(mag_in) * 32'(TICKS_PER_DEG);
        end
        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Free-running PWM slot counter advanced by the prescaler
    always_comb begin
        pre_d  = pre_q == 32'(PWM_DIV - 1) ? '0 : pre_q + 32'd1;
        slot_d = pre_q == 32'(PWM_DIV - 1) ? slot_q + 2'd1 : slot_q;
    end

    // Moore outputs from the next state so they change on the same edge as the state
    always_comb begin
        drive_n     = state_d == DRIVE;
        spin_n      = state_d == SPIN;
        duty        = spin_n ? 2'd3 : drive_n ? bus.speed[1:0] : 2'd0;
        left_dir_d  = spin_n ? ~dir_d : drive_n & ~bus.speed[2];
        right_dir_d = spin_n ? dir_d : drive_n & ~bus.speed[2];
        left_pwm_d  = slot_d < duty;
        right_pwm_d = slot_d < duty;
        done_d      = state_d == DONE;
`ifdef MOTION_BRAKE_EN
        busy_d      = spin_n | (state_d == BRAKE);
`else
        busy_d      = spin_n;
`endif
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lcmd_q      <= '0;
            dir_q       <= 1'b0;
            mag_q       <= '0;
            slot_q      <= '0;
            pre_q       <= '0;
`ifdef MOTION_BRAKE_EN
            brk_q       <= '0;
`endif
            left_dir_q  <= 1'b0;
            right_dir_q <= 1'b0;
            left_pwm_q  <= 1'b0;
            right_pwm_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lcmd_q      <= lcmd_d;
            dir_q       <= dir_d;
            mag_q       <= mag_d;
            slot_q      <= slot_d;
            pre_q       <= pre_d;
`ifdef MOTION_BRAKE_EN
            brk_q       <= brk_d;
`endif
            left_dir_q  <= left_dir_d;
            right_dir_q <= right_dir_d;
            left_pwm_q  <= left_pwm_d;
            right_pwm_q <= right_pwm_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.left_dir  = left_dir_q;
    assign bus.right_dir = right_dir_q;
    assign bus.left_pwm  = left_pwm_q;
    assign bus.right_pwm = right_pwm_q;
    assign bus.done_spin = done_q;
    assign bus.busy      = busy_q;
endmodule
